psl_cmd_arbiter: RTL and testbench

AFU-side PSL command scheduler. It shares the single PSL command interface (ah_c*) between NREQ internal requesters, such as a read engine and a write engine. It allocates command tags from a free pool, enforces the PSL command credit limit from ha_croom and ha_rcredits, generates the odd-parity bits, and routes each ha_r* response back to the requester that owns the tag.

---
 rtl/psl_pkg.sv | 41 ++++
 rtl/psl_tag_pool.sv | 75 +++++++
 rtl/psl_cmd_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_psl_cmd_arbiter.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psl_pkg.sv
// Shared PSL definitions: command opcodes, response codes, FSM state type, parity helper.
package psl_pkg;

    // PSL command opcodes
    localparam logic [12:0] PSL_READ_CL_NA  = 13'h0A00;
    localparam logic [12:0] PSL_READ_CL_S   = 13'h0A50;
    localparam logic [12:0] PSL_READ_CL_M   = 13'h0A60;
    localparam logic [12:0] PSL_READ_CL_LCK = 13'h0A6B;
    localparam logic [12:0] PSL_READ_CL_RES = 13'h0A67;
    localparam logic [12:0] PSL_READ_PNA    = 13'h0E00;
    localparam logic [12:0] PSL_WRITE_NA    = 13'h0D00;
    localparam logic [12:0] PSL_WRITE_INJ   = 13'h0D10;
    localparam logic [12:0] PSL_WRITE_MI    = 13'h0D60;
    localparam logic [12:0] PSL_WRITE_MS    = 13'h0D70;

    // PSL response codes
    localparam logic [7:0] PSL_RSP_DONE    = 8'h00;
    localparam logic [7:0] PSL_RSP_AERROR  = 8'h01;
    localparam logic [7:0] PSL_RSP_DERROR  = 8'h03;
    localparam logic [7:0] PSL_RSP_NLOCK   = 8'h04;
    localparam logic [7:0] PSL_RSP_NRES    = 8'h05;
    localparam logic [7:0] PSL_RSP_FLUSHED = 8'h06;
    localparam logic [7:0] PSL_RSP_FAULT   = 8'h07;
    localparam logic [7:0] PSL_RSP_FAILED  = 8'h08;
    localparam logic [7:0] PSL_RSP_PAGED   = 8'h0A;
    localparam logic [7:0] PSL_RSP_CONTEXT = 8'h0B;

    // Requester index width (NREQ is at most 4)
    localparam int REQ_IDX_W = 2;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_e;

    // Odd parity: zero-extension leaves the XNOR-reduce of a narrower field unchanged
    function automatic logic odd_parity(input logic [63:0] v);
        return ~^v;
    endfunction

endpackage

// File: rtl/psl_tag_pool.sv
// Command tag pool: free bitmap, lowest-free encoder, owner table, in-flight count.
module psl_tag_pool
    import psl_pkg::*;
#(
    parameter int NTAGS = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 alloc_i,
    input  logic [REQ_IDX_W-1:0] alloc_owner_i,
    input  logic                 rel_valid_i,
    input  logic [7:0]           rel_tag_i,
    output logic                 free_any_o,
    output logic [7:0]           free_tag_o,
    output logic                 rel_ok_o,
    output logic [REQ_IDX_W-1:0] rel_owner_o,
    output logic [7:0]           outstanding_o
);

    localparam int TW = $clog2(NTAGS);

    logic [NTAGS-1:0]     free_q, free_d;
    logic [REQ_IDX_W-1:0] owner_q [NTAGS];
    logic [7:0]           outstanding_q, outstanding_d;
    logic [TW-1:0]        low_tag;
    logic [TW-1:0]        rel_idx;
    logic                 rel_in_range;
    int                   busy;

    assign rel_in_range  = ({1'b0, rel_tag_i} < 9'(NTAGS));
    assign rel_idx       = rel_tag_i[TW-1:0];
    // A tag allocated this cycle is still marked free, so a same-cycle response to it is rejected
    assign rel_ok_o      = rel_valid_i && rel_in_range && !free_q[rel_idx];
    assign rel_owner_o   = owner_q[rel_idx];
    assign free_any_o    = |free_q;
    assign free_tag_o    = 8'(low_tag);
    assign outstanding_o = outstanding_q;

    // Priority encoder: lowest-index free tag wins
    always_comb begin
        low_tag = '0;
        for (int t = NTAGS - 1; t >= 0; t--) begin
            if (free_q[t]) low_tag = TW'(t);
        end
    end

    // Next free map and in-flight count
    always_comb begin
        free_d = free_q;
        busy   = 0;
        if (rel_ok_o) free_d[rel_idx] = 1'b1;
        if (alloc_i)  free_d[low_tag] = 1'b0;
        for (int t = 0; t < NTAGS; t++) begin
            if (!free_d[t]) busy++;
        end
        outstanding_d = 8'(busy);
    end

    // Free map and count registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            free_q        <= '1;
            outstanding_q <= '0;
        end else begin
            free_q        <= free_d;
            outstanding_q <= outstanding_d;
        end
    end

    // Owner table written on allocation
    always_ff @(posedge clk_i) begin
        if (alloc_i) owner_q[low_tag] <= alloc_owner_i;
    end

endmodule

// File: rtl/psl_cmd_arbiter.sv
// PSL command scheduler: round-robin grant, credit tracking, tag allocation, response routing.
module psl_cmd_arbiter
    import psl_pkg::*;
#(
    parameter int          NREQ  = 2,
    parameter int          NTAGS = 32,
    parameter logic [2:0]  CABT  = 3'b000,
    parameter logic [15:0] CCH   = 16'h0000
) (
    input  logic                 ha_pclock,
    input  logic                 rst,
    input  logic [7:0]           ha_croom,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [13*NREQ-1:0]   req_com,
    input  logic [64*NREQ-1:0]   req_cea,
    input  logic [12*NREQ-1:0]   req_csize,
    output logic [7:0]           req_tag,
    output logic                 ah_cvalid,
    output logic [7:0]           ah_ctag,
    output logic                 ah_ctagpar,
    output logic [12:0]          ah_com,
    output logic                 ah_compar,
    output logic [2:0]           ah_cabt,
    output logic [63:0]          ah_cea,
    output logic                 ah_ceapar,
    output logic [15:0]          ah_cch,
    output logic [11:0]          ah_csize,
    input  logic                 ha_rvalid,
    input  logic [7:0]           ha_rtag,
    input  logic [7:0]           ha_response,
    input  logic [8:0]           ha_rcredits,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [7:0]           rsp_tag,
    output logic [7:0]           rsp_code,
    output logic [7:0]           outstanding,
    output logic                 err_badtag
);

    arb_state_e              state_q, state_d;
    logic signed [8:0]       credits_q, credits_d;
    logic signed [10:0]      cred_ext, rc_ext, cred_sum;
    logic [REQ_IDX_W-1:0]    rr_q, rr_d, win;
    logic                    grant;
    int                      idx;
    logic [12:0]             sel_com;
    logic [63:0]             sel_cea;
    logic [11:0]             sel_csize;
    logic                    free_any, rel_ok;
    logic [7:0]              free_tag;
    logic [REQ_IDX_W-1:0]    rel_owner;
    logic [NREQ-1:0]         owner_onehot;
    logic                    cvalid_q;
    logic [7:0]              ctag_q;
    logic [12:0]             com_q;
    logic [63:0]             cea_q;
    logic [11:0]             csize_q;
    logic [NREQ-1:0]         rsp_valid_q;
    logic [7:0]              rsp_tag_q, rsp_code_q;
    logic                    err_q;

    function automatic logic signed [8:0] sat_credits(input logic signed [10:0] v);
        if (v < 11'sd0)   return 9'sd0;
        if (v > 11'sd255) return 9'sd255;
        return 9'(v);
    endfunction

    psl_tag_pool #(.NTAGS(NTAGS)) u_pool (
        .clk_i         (ha_pclock),
        .rst_i         (rst),
        .alloc_i       (grant),
        .alloc_owner_i (win),
        .rel_valid_i   (ha_rvalid),
        .rel_tag_i     (ha_rtag),
        .free_any_o    (free_any),
        .free_tag_o    (free_tag),
        .rel_ok_o      (rel_ok),
        .rel_owner_o   (rel_owner),
        .outstanding_o (outstanding)
    );

    // FSM state register
    always_ff @(posedge ha_pclock) begin
        if (rst) state_q <= ST_INIT;
        else     state_q <= state_d;
    end

    // FSM next state: INIT lasts exactly one cycle
    always_comb begin
        state_d = state_q;
        if (state_q == ST_INIT) state_d = ST_RUN;
    end

    // Round-robin grant; the scan runs backwards so the first requester after rr_q wins
    always_comb begin
        grant = 1'b0;
        win   = '0;
        idx   = 0;
        if ((state_q == ST_RUN) && !rst && (credits_q > 9'sd0) && free_any) begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                idx = (int'(rr_q) + k) % NREQ;
                if (req_valid[idx]) begin
                    grant = 1'b1;
                    win   = REQ_IDX_W'(idx);
                end
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = grant && (win == REQ_IDX_W'(i));
        end
        rr_d = grant ? REQ_IDX_W'((int'(win) + 1) % NREQ) : rr_q;
    end

    // Select the winning requester's command fields
    always_comb begin
        sel_com   = '0;
        sel_cea   = '0;
        sel_csize = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                sel_com   = req_com[13*i +: 13];
                sel_cea   = req_cea[64*i +: 64];
                sel_csize = req_csize[12*i +: 12];
            end
        end
    end

    // Credit next value: load in INIT, otherwise add response credits and subtract an issue
    always_comb begin
        cred_ext  = 11'(credits_q);
        rc_ext    = ha_rvalid ? 11'(signed'(ha_rcredits)) : 11'sd0;
        cred_sum  = cred_ext + rc_ext - (grant ? 11'sd1 : 11'sd0);
        credits_d = (state_q == ST_INIT) ? signed'({1'b0, ha_croom}) : sat_credits(cred_sum);
    end

    // Credit and round-robin pointer registers
    always_ff @(posedge ha_pclock) begin
        if (rst) begin
            credits_q <= '0;
            rr_q      <= '0;
        end else begin
            credits_q <= credits_d;
            rr_q      <= rr_d;
        end
    end

    // Command issue register: one-cycle latency from transfer to ah_cvalid
    always_ff @(posedge ha_pclock) begin
        if (rst) begin
            cvalid_q <= 1'b0;
            ctag_q   <= '0;
            com_q    <= '0;
            cea_q    <= '0;
            csize_q  <= '0;
        end else begin
            cvalid_q <= grant;
            if (grant) begin
                ctag_q  <= free_tag;
                com_q   <= sel_com;
                cea_q   <= sel_cea;
                csize_q <= sel_csize;
            end
        end
    end

    // One-hot owner decode for response routing
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            owner_onehot[i] = (rel_owner == REQ_IDX_W'(i));
        end
    end

    // Response routing register and sticky bad-tag flag
    always_ff @(posedge ha_pclock) begin
        if (rst) begin
            rsp_valid_q <= '0;
            rsp_tag_q   <= '0;
            rsp_code_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            rsp_valid_q <= '0;
            if (ha_rvalid) begin
                rsp_tag_q  <= ha_rtag;
                rsp_code_q <= ha_response;
                if (rel_ok) rsp_valid_q <= owner_onehot;
                else        err_q       <= 1'b1;
            end
        end
    end

    assign req_tag    = free_tag;
    assign ah_cvalid  = cvalid_q;
    assign ah_ctag    = ctag_q;
    assign ah_ctagpar = odd_parity(64'(ctag_q));
    assign ah_com     = com_q;
    assign ah_compar  = odd_parity(64'(com_q));
    assign ah_cabt    = CABT;
    assign ah_cea     = cea_q;
    assign ah_ceapar  = odd_parity(cea_q);
    assign ah_cch     = CCH;
    assign ah_csize   = csize_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_tag    = rsp_tag_q;
    assign rsp_code   = rsp_code_q;
    assign err_badtag = err_q;

endmodule

// File: tb/tb_psl_cmd_arbiter.sv
// Self-checking bench for psl_cmd_arbiter with a reference model and command/response scoreboards.
module tb_psl_cmd_arbiter;
    import psl_pkg::*;

    localparam int NREQ  = 2;
    localparam int NTAGS = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [7:0]           ha_croom;
    logic [NREQ-1:0]      req_valid, req_ready;
    logic [13*NREQ-1:0]   req_com;
    logic [64*NREQ-1:0]   req_cea;
    logic [12*NREQ-1:0]   req_csize;
    logic [7:0]           req_tag;
    logic                 ah_cvalid, ah_ctagpar, ah_compar, ah_ceapar;
    logic [7:0]           ah_ctag;
    logic [12:0]          ah_com;
    logic [2:0]           ah_cabt;
    logic [63:0]          ah_cea;
    logic [15:0]          ah_cch;
    logic [11:0]          ah_csize;
    logic                 ha_rvalid;
    logic [7:0]           ha_rtag, ha_response;
    logic [8:0]           ha_rcredits;
    logic [NREQ-1:0]      rsp_valid;
    logic [7:0]           rsp_tag, rsp_code, outstanding;
    logic                 err_badtag;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    psl_cmd_arbiter #(.NREQ(NREQ), .NTAGS(NTAGS), .CABT(3'b000), .CCH(16'h0000)) dut (
        .ha_pclock(clk), .rst(rst), .ha_croom(ha_croom),
        .req_valid(req_valid), .req_ready(req_ready), .req_com(req_com),
        .req_cea(req_cea), .req_csize(req_csize), .req_tag(req_tag),
        .ah_cvalid(ah_cvalid), .ah_ctag(ah_ctag), .ah_ctagpar(ah_ctagpar),
        .ah_com(ah_com), .ah_compar(ah_compar), .ah_cabt(ah_cabt),
        .ah_cea(ah_cea), .ah_ceapar(ah_ceapar), .ah_cch(ah_cch), .ah_csize(ah_csize),
        .ha_rvalid(ha_rvalid), .ha_rtag(ha_rtag), .ha_response(ha_response),
        .ha_rcredits(ha_rcredits), .rsp_valid(rsp_valid), .rsp_tag(rsp_tag),
        .rsp_code(rsp_code), .outstanding(outstanding), .err_badtag(err_badtag)
    );

    typedef struct { logic [7:0] tag; logic [12:0] com; logic [63:0] cea; logic [11:0] csize; } cmd_t;
    typedef struct { int req; logic [7:0] tag; logic [7:0] code; } rsp_t;
    cmd_t cmd_q[$];
    rsp_t rsp_q[$];

    // reference model
    bit             m_run;
    int             m_cred;
    bit [NTAGS-1:0] m_free;
    int             m_owner [NTAGS];
    int             m_rr;
    bit             m_err;

    // last-cycle grant seen by the bench
    bit g_xfer;
    int g_win;
    int g_tag;

    // One clock cycle: predict grant, check it, advance the model, then check registered outputs.
    task automatic tick();
        int win, low, rc, busy;
        bit elig;
        logic [NREQ-1:0] exp_ready, exp_rsp;
        cmd_t c;
        rsp_t r;
        #1;
        win = -1;
        low = -1;
        for (int t = 0; t < NTAGS; t++) if (m_free[t] && low < 0) low = t;
        elig = m_run && !rst && (m_cred > 0) && (low >= 0);
        if (elig) begin
            for (int k = 0; k < NREQ; k++) begin
                int ix;
                ix = (m_rr + k) % NREQ;
                if (req_valid[ix] && win < 0) win = ix;
            end
        end
        exp_ready = '0;
        if (win >= 0) exp_ready[win] = 1'b1;
        checks++;
        if (req_ready !== exp_ready) begin
            errors++;
            $display("FAIL req_ready: got %b expected %b", req_ready, exp_ready);
        end
        if (win >= 0) begin
            checks++;
            if (req_tag !== 8'(low)) begin
                errors++;
                $display("FAIL req_tag: got %0d expected %0d", req_tag, low);
            end
            c.tag = 8'(low);
            c.com = req_com[13*win +: 13];
            c.cea = req_cea[64*win +: 64];
            c.csize = req_csize[12*win +: 12];
            cmd_q.push_back(c);
        end
        g_xfer = (win >= 0);
        g_win  = win;
        g_tag  = low;
        // model update at the clock edge
        if (rst) begin
            m_run = 0; m_cred = 0; m_free = '1; m_err = 0; m_rr = 0;
        end else begin
            if (ha_rvalid) begin
                if (ha_rtag < NTAGS && !m_free[ha_rtag]) begin
                    r.req = m_owner[ha_rtag]; r.tag = ha_rtag; r.code = ha_response;
                    rsp_q.push_back(r);
                    m_free[ha_rtag] = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (win >= 0) begin
                m_free[low] = 1'b0;
                m_owner[low] = win;
                m_rr = (win + 1) % NREQ;
            end
            if (!m_run) begin
                m_cred = ha_croom;
                m_run = 1;
            end else begin
                rc = ha_rvalid ? int'(signed'(ha_rcredits)) : 0;
                m_cred = m_cred + rc - ((win >= 0) ? 1 : 0);
                if (m_cred < 0) m_cred = 0;
                if (m_cred > 255) m_cred = 255;
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (ah_cvalid !== g_xfer) begin
            errors++;
            $display("FAIL ah_cvalid: got %b expected %b", ah_cvalid, g_xfer);
        end
        if (g_xfer && cmd_q.size() > 0) begin
            c = cmd_q.pop_front();
            checks++;
            if (ah_ctag !== c.tag || ah_com !== c.com || ah_cea !== c.cea || ah_csize !== c.csize) begin
                errors++;
                $display("FAIL cmd_fields: got tag=%0d com=%h cea=%h size=%0d expected tag=%0d com=%h cea=%h size=%0d",
                         ah_ctag, ah_com, ah_cea, ah_csize, c.tag, c.com, c.cea, c.csize);
            end
            checks++;
            if (ah_ctagpar !== ~^c.tag || ah_compar !== ~^c.com || ah_ceapar !== ~^c.cea) begin
                errors++;
                $display("FAIL cmd_parity: got %b%b%b expected %b%b%b", ah_ctagpar, ah_compar, ah_ceapar,
                         ~^c.tag, ~^c.com, ~^c.cea);
            end
        end
        exp_rsp = '0;
        if (rsp_q.size() > 0) begin
            r = rsp_q.pop_front();
            exp_rsp[r.req] = 1'b1;
            checks++;
            if (rsp_tag !== r.tag || rsp_code !== r.code) begin
                errors++;
                $display("FAIL rsp_fields: got tag=%0d code=%h expected tag=%0d code=%h", rsp_tag, rsp_code, r.tag, r.code);
            end
        end
        checks++;
        if (rsp_valid !== exp_rsp) begin
            errors++;
            $display("FAIL rsp_valid: got %b expected %b", rsp_valid, exp_rsp);
        end
        checks++;
        if (err_badtag !== m_err) begin
            errors++;
            $display("FAIL err_badtag: got %b expected %b", err_badtag, m_err);
        end
        busy = 0;
        for (int t = 0; t < NTAGS; t++) if (!m_free[t]) busy++;
        checks++;
        if (outstanding !== 8'(busy)) begin
            errors++;
            $display("FAIL outstanding: got %0d expected %0d", outstanding, busy);
        end
    endtask

    task automatic do_reset(input logic [7:0] croom);
        req_valid = '0;
        ha_rvalid = 1'b0;
        ha_croom  = croom;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic respond(input logic [7:0] tag, input logic [7:0] code, input logic [8:0] rc);
        ha_rvalid   = 1'b1;
        ha_rtag     = tag;
        ha_response = code;
        ha_rcredits = rc;
    endtask

    task automatic test_reset();
        ha_croom = 8'd4;
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({ah_cvalid, ah_ctag, ah_com, ah_cea, ah_csize, ah_cabt, ah_cch} !== '0) begin
            errors++;
            $display("FAIL reset_cmd: got cvalid=%b tag=%0d com=%h cea=%h", ah_cvalid, ah_ctag, ah_com, ah_cea);
        end
        checks++;
        if ({ah_ctagpar, ah_compar, ah_ceapar} !== 3'b111) begin
            errors++;
            $display("FAIL reset_parity: got %b%b%b expected 111", ah_ctagpar, ah_compar, ah_ceapar);
        end
        checks++;
        if ({rsp_valid, rsp_tag, rsp_code, outstanding, err_badtag} !== '0) begin
            errors++;
            $display("FAIL reset_rsp: got rsp_valid=%b outstanding=%0d err=%b", rsp_valid, outstanding, err_badtag);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_credit_limit();
        int n;
        int tags[$];
        do_reset(8'd4);
        req_valid = 2'b01;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (g_xfer) tags.push_back(g_tag);
        end
        n = tags.size();
        checks++;
        if (n != 4 || tags[0] != 0 || tags[1] != 1 || tags[2] != 2 || tags[3] != 3) begin
            errors++;
            $display("FAIL credit_limit_grants: got %0d grants expected 4 with tags 0..3", n);
        end
        #1;
        checks++;
        if (req_ready !== 2'b00 || outstanding !== 8'd4) begin
            errors++;
            $display("FAIL credit_limit_idle: got ready=%b outstanding=%0d expected 00 and 4", req_ready, outstanding);
        end
        // negative credit return saturates at zero, then +2 allows exactly two grants
        respond(8'd0, PSL_RSP_DONE, 9'h1FB);
        tick();
        respond(8'd1, PSL_RSP_PAGED, 9'd2);
        tick();
        ha_rvalid = 1'b0;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (g_xfer) n++;
        end
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL credit_floor: got %0d grants expected 2", n);
        end
    endtask

    task automatic test_round_robin();
        int bad;
        do_reset(8'd32);
        req_com   = {PSL_WRITE_NA, PSL_READ_CL_NA};
        req_csize = {12'd64, 12'd128};
        req_valid = 2'b11;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            req_cea = {$urandom, $urandom, $urandom, $urandom};
            tick();
            if (!g_xfer || g_win != (i % 2) || g_tag != i) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL round_robin: got %0d bad grants expected 0", bad);
        end
    endtask

    task automatic test_rsp_same_cycle();
        req_valid = 2'b01;
        respond(8'd2, PSL_RSP_DONE, 9'd1);
        tick();
        checks++;
        if (!g_xfer || g_tag != 8) begin
            errors++;
            $display("FAIL same_cycle_tag: got xfer=%b tag=%0d expected 1 and 8", g_xfer, g_tag);
        end
        checks++;
        if (rsp_valid !== 2'b01) begin
            errors++;
            $display("FAIL rsp_owner0: got %b expected 01", rsp_valid);
        end
        respond(8'd3, PSL_RSP_AERROR, 9'd0);
        tick();
        checks++;
        if (!g_xfer || g_tag != 2) begin
            errors++;
            $display("FAIL reissue_tag: got xfer=%b tag=%0d expected 1 and 2", g_xfer, g_tag);
        end
        checks++;
        if (rsp_valid !== 2'b10 || rsp_code !== PSL_RSP_AERROR) begin
            errors++;
            $display("FAIL rsp_owner1: got %b code %h expected 10 code 01", rsp_valid, rsp_code);
        end
        ha_rvalid = 1'b0;
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_badtag();
        do_reset(8'd4);
        req_valid = 2'b01;
        for (int i = 0; i < 4; i++) tick();
        req_valid = 2'b00;
        respond(8'd9, PSL_RSP_DONE, 9'd0);
        tick();
        ha_rvalid = 1'b0;
        checks++;
        if (rsp_valid !== 2'b00 || err_badtag !== 1'b1) begin
            errors++;
            $display("FAIL badtag: got rsp_valid=%b err=%b expected 00 and 1", rsp_valid, err_badtag);
        end
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (err_badtag !== 1'b1) begin
            errors++;
            $display("FAIL badtag_sticky: got %b expected 1", err_badtag);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (err_badtag !== 1'b0) begin
            errors++;
            $display("FAIL badtag_clear: got %b expected 0", err_badtag);
        end
    endtask

    task automatic test_tag_exhaust();
        int n;
        do_reset(8'd64);
        req_valid = 2'b11;
        n = 0;
        for (int i = 0; i < 34; i++) begin
            req_cea = {$urandom, $urandom, $urandom, $urandom};
            tick();
            if (g_xfer) n++;
        end
        #1;
        checks++;
        if (n != 32 || req_ready !== 2'b00 || outstanding !== 8'd32) begin
            errors++;
            $display("FAIL tag_exhaust: got grants=%0d ready=%b outstanding=%0d expected 32, 00, 32", n, req_ready, outstanding);
        end
        respond(8'd17, PSL_RSP_DONE, 9'd0);
        tick();
        ha_rvalid = 1'b0;
        checks++;
        if (g_xfer) begin
            errors++;
            $display("FAIL tag_free_latency: got grant with tag %0d expected none", g_tag);
        end
        tick();
        checks++;
        if (!g_xfer || g_tag != 17) begin
            errors++;
            $display("FAIL tag_reuse: got xfer=%b tag=%0d expected 1 and 17", g_xfer, g_tag);
        end
        tick();
        checks++;
        if (g_xfer) begin
            errors++;
            $display("FAIL tag_single: got extra grant tag %0d expected none", g_tag);
        end
    endtask

    task automatic test_reset_midburst();
        int n;
        do_reset(8'd8);
        req_valid = 2'b01;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        tick();
        checks++;
        if (ah_cvalid !== 1'b0 || outstanding !== 8'd0) begin
            errors++;
            $display("FAIL midburst_reset: got cvalid=%b outstanding=%0d expected 0 and 0", ah_cvalid, outstanding);
        end
        rst = 1'b0;
        ha_croom = 8'd2;
        req_valid = 2'b00;
        tick();
        respond(8'd1, PSL_RSP_DONE, 9'd0);
        tick();
        ha_rvalid = 1'b0;
        checks++;
        if (err_badtag !== 1'b1 || rsp_valid !== 2'b00) begin
            errors++;
            $display("FAIL late_rsp: got err=%b rsp_valid=%b expected 1 and 00", err_badtag, rsp_valid);
        end
        req_valid = 2'b01;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (g_xfer) n++;
        end
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL croom_reload: got %0d grants expected 2", n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst         = 1'b1;
        ha_croom    = 8'd4;
        req_valid   = '0;
        req_com     = {PSL_WRITE_MI, PSL_READ_CL_S};
        req_cea     = {64'h0000_1000_2000_3000, 64'h8000_0000_0000_0080};
        req_csize   = {12'd128, 12'd128};
        ha_rvalid   = 1'b0;
        ha_rtag     = '0;
        ha_response = '0;
        ha_rcredits = '0;
        m_run = 0; m_cred = 0; m_free = '1; m_err = 0; m_rr = 0;
        for (int t = 0; t < NTAGS; t++) m_owner[t] = 0;
        test_reset();
        test_credit_limit();
        test_round_robin();
        test_rsp_same_cycle();
        test_badtag();
        test_tag_exhaust();
        test_reset_midburst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
